// File: rtl/ddr3_req_sched.sv
// Two-port DDR3 transfer scheduler: arbitrates port requests, launches one UI-engine
// transfer at a time and reports completion/fault. DDR3_SCHED_FIXED_PRIO_EN selects fixed port-0 priority.
module ddr3_req_sched #(
  parameter int BUF_DEPTH      = 10,
  parameter int MEM_ADDR_DEPTH = 28
) (
  input  logic                        ui_clk,
  input  logic                        rst,
  input  logic                        i_app_phy_init_done,
  input  logic [1:0]                  i_req,
  input  logic [1:0]                  i_wr,
  input  logic [2*MEM_ADDR_DEPTH-1:0] i_addr,
  input  logic [2*BUF_DEPTH-1:0]      i_count,
  input  logic [2*BUF_DEPTH-1:0]      i_start,
  output logic [1:0]                  o_ack,
  output logic [1:0]                  o_done,
  output logic [1:0]                  o_fault,
  output logic [MEM_ADDR_DEPTH-1:0]   o_xfer_ddr3_addr,
  output logic [BUF_DEPTH-1:0]        o_xfer_count,
  output logic [BUF_DEPTH-1:0]        o_xfer_start,
  output logic                        o_ibuf_go,
  output logic                        o_obuf_go,
  input  logic                        i_ibuf_bsy,
  input  logic                        i_obuf_bsy,
  input  logic                        i_ibuf_ddr3_fault,
  input  logic                        i_obuf_ddr3_fault,
  output logic [1:0]                  o_sch_state
);

  // Handshake: i_req is a level sampled only in SCH_IDLE; o_ack/o_done are single-cycle
  // pulses; go stays high until the matching engine busy is sampled high (or the issue timer expires).
  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_BUSY  = 2'd2,
    SCH_DONE  = 2'd3
  } sch_state_t;

  sch_state_t r_state;
  logic       r_port;
  logic       r_wr;
  logic       r_fault;
  logic [3:0] r_timer;

  logic                      grant_port;
  logic [MEM_ADDR_DEPTH-1:0] sel_addr;
  logic [BUF_DEPTH-1:0]      sel_count;
  logic [BUF_DEPTH-1:0]      sel_start;
  logic                      sel_wr;
  logic                      eng_bsy;
  logic                      eng_fault;

  function automatic logic [1:0] port_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

`ifdef DDR3_SCHED_FIXED_PRIO_EN
  assign grant_port = ~i_req[0];
`else
  logic r_last;

  // With both ports asking, the one not served last wins.
  always_comb begin
    grant_port = i_req[1];
    if (i_req == 2'b11) begin
      grant_port = ~r_last;
    end
  end
`endif

  assign sel_addr  = grant_port ? i_addr[2*MEM_ADDR_DEPTH-1:MEM_ADDR_DEPTH] : i_addr[MEM_ADDR_DEPTH-1:0];
  assign sel_count = grant_port ? i_count[2*BUF_DEPTH-1:BUF_DEPTH] : i_count[BUF_DEPTH-1:0];
  assign sel_start = grant_port ? i_start[2*BUF_DEPTH-1:BUF_DEPTH] : i_start[BUF_DEPTH-1:0];
  assign sel_wr    = i_wr[grant_port];

  assign eng_bsy   = r_wr ? i_ibuf_bsy : i_obuf_bsy;
  assign eng_fault = r_wr ? i_ibuf_ddr3_fault : i_obuf_ddr3_fault;

  assign o_fault     = o_done & {2{r_fault}};
  assign o_sch_state = r_state;

  always_ff @(posedge ui_clk or posedge rst) begin
    if (rst) begin
      r_state          <= SCH_IDLE;
      r_port           <= 1'b0;
      r_wr             <= 1'b0;
      r_fault          <= 1'b0;
      r_timer          <= 4'd0;
      o_ack            <= 2'b00;
      o_done           <= 2'b00;
      o_ibuf_go        <= 1'b0;
      o_obuf_go        <= 1'b0;
      o_xfer_ddr3_addr <= '0;
      o_xfer_count     <= '0;
      o_xfer_start     <= '0;
`ifndef DDR3_SCHED_FIXED_PRIO_EN
      r_last           <= 1'b1;
`endif
    end else begin
      o_ack  <= 2'b00;
      o_done <= 2'b00;
      case (r_state)
        SCH_IDLE: begin
          if (i_app_phy_init_done && (i_req != 2'b00)) begin
            o_ack            <= port_mask(grant_port);
            r_port           <= grant_port;
            r_wr             <= sel_wr;
            r_fault          <= 1'b0;
            r_timer          <= 4'd0;
            o_xfer_ddr3_addr <= sel_addr;
            o_xfer_count     <= sel_count;
            o_xfer_start     <= sel_start;
            // Go rises together with ack so the engine starts one cycle after the request.
            if (sel_count != '0) begin
              o_ibuf_go <= sel_wr;
              o_obuf_go <= ~sel_wr;
            end
`ifndef DDR3_SCHED_FIXED_PRIO_EN
            r_last           <= grant_port;
`endif
            r_state          <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          if (o_xfer_count == '0) begin
            o_done  <= port_mask(r_port);
            r_state <= SCH_DONE;
          end else if (eng_bsy) begin
            o_ibuf_go <= 1'b0;
            o_obuf_go <= 1'b0;
            r_state   <= SCH_BUSY;
          end else if (r_timer == 4'd15) begin
            o_ibuf_go <= 1'b0;
            o_obuf_go <= 1'b0;
            r_fault   <= 1'b1;
            o_done    <= port_mask(r_port);
            r_state   <= SCH_DONE;
          end else begin
            r_timer <= r_timer + 4'd1;
          end
        end
        SCH_BUSY: begin
          if (!eng_bsy) begin
            r_fault <= eng_fault;
            o_done  <= port_mask(r_port);
            r_state <= SCH_DONE;
          end
        end
        SCH_DONE: begin
          r_state <= SCH_IDLE;
        end
        default: begin
          r_state <= SCH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ddr3_req_sched.md
DDR3_REQ_SCHED -- requirements
Module: ddr3_req_sched

Interface
REQ-001 Parameter BUF_DEPTH, default 10, width of buffer word count and start address.
REQ-002 Parameter MEM_ADDR_DEPTH, default 28, width of DDR3 address.
REQ-003 ui_clk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_app_phy_init_done  in  1  DDR3 calibration complete; no grant while low.
REQ-006 i_req  in  2  per-port transfer request, level; bit n = port n.
REQ-007 i_wr  in  2  per-port direction: 1 = ibuf->DDR3 write, 0 = DDR3->obuf read.
REQ-008 i_addr  in  2*MEM_ADDR_DEPTH  per-port DDR3 address; port n at [n*MEM_ADDR_DEPTH +: MEM_ADDR_DEPTH].
REQ-009 i_count  in  2*BUF_DEPTH  per-port transfer count, same packing.
REQ-010 i_start  in  2*BUF_DEPTH  per-port buffer start address, same packing.
REQ-011 o_ack  out  2  one-cycle grant pulse; parameters captured.
REQ-012 o_done  out  2  one-cycle completion pulse.
REQ-013 o_fault  out  2  fault status, valid only in the o_done cycle.
REQ-014 o_xfer_ddr3_addr  out  MEM_ADDR_DEPTH  latched address to both ibuf_ddr3_addrb and obuf_ddr3_addra.
REQ-015 o_xfer_count  out  BUF_DEPTH  latched count to both ibuf and obuf count.
REQ-016 o_xfer_start  out  BUF_DEPTH  latched start to ibuf_start_addrb and obuf_start_addra.
REQ-017 o_ibuf_go / o_obuf_go  out  1 each  start write / read transfer in the UI engine.
REQ-018 i_ibuf_bsy / i_obuf_bsy  in  1 each  UI engine busy with write / read.
REQ-019 i_ibuf_ddr3_fault / i_obuf_ddr3_fault  in  1 each  UI engine timeout fault.

Function
REQ-020 FSM states SCH_IDLE, SCH_ISSUE, SCH_BUSY, SCH_DONE; exactly one transfer outstanding.
REQ-021 SCH_IDLE: if i_app_phy_init_done=1 and any i_req bit set, grant one port; next cycle o_ack[n]=1, parameters latched into o_xfer_*, r_wr latched, state SCH_ISSUE.
REQ-022 Arbitration: round-robin; with both requesting, grant the port not granted last; last-grant register resets to 1 (port 0 wins first).
REQ-023 SCH_ISSUE: drive o_ibuf_go (r_wr=1) or o_obuf_go (r_wr=0) high every cycle until matching bsy sampled 1; then go low next cycle, state SCH_BUSY.
REQ-024 SCH_ISSUE timeout: matching bsy not seen within 16 cycles -> go low, fault flag set, state SCH_DONE.
REQ-025 SCH_BUSY: when matching bsy sampled 0, capture matching ddr3_fault into fault flag, state SCH_DONE.
REQ-026 SCH_DONE: o_done[n]=1 and o_fault[n]=flag for one cycle; state SCH_IDLE; no grant in this cycle.
REQ-027 i_count of zero: ack, no go issued, o_done next cycle with o_fault=0.
REQ-028 i_req sampled only in SCH_IDLE; a request held through o_done is a new transfer.
REQ-029 o_xfer_* stable from ack until the next ack.
REQ-030 Minimum latency i_req to o_ibuf_go/o_obuf_go: 1 cycle; o_done 1 cycle after bsy falls.
REQ-031 i_app_phy_init_done falling mid-transfer does not abort; gates new grants only.

Reset
REQ-032 rst asserted: state SCH_IDLE, o_ack=0, o_done=0, o_fault=0, both go=0, o_xfer_*=0, fault flag 0, last-grant=1, issue timer 0, immediately (asynchronous).
REQ-033 Reset mid-transfer abandons it; no o_done issued for the abandoned port.

Configuration
REQ-034 Macro DDR3_SCHED_FIXED_PRIO_EN defined: port 0 always wins when both request; last-grant register absent.
REQ-035 Macro undefined: round-robin per REQ-022.

Verification
REQ-036 Port0 write, addr 0x100, count 16, bsy high 2 cycles after go for 20 cycles -> o_ack[0] next cycle, o_ibuf_go until bsy, o_done[0]=1 with o_fault[0]=0.
REQ-037 Both ports request continuously -> grants alternate 0,1,0,1 (macro undefined); 0,0,0,0 (macro defined).
REQ-038 Port1 read, bsy falls with i_obuf_ddr3_fault=1 -> o_done[1]=1, o_fault[1]=1.
REQ-039 Port0 write, bsy never rises -> go high 16 cycles then low, o_done[0]=1, o_fault[0]=1.
REQ-040 i_app_phy_init_done=0 with i_req=2'b11 -> no ack; raise init_done -> o_ack[0] next cycle; count=0 request -> ack then done, no go.
